// File: rtl/mips_pkg.sv
// mips_pkg: shared op/state encodings for the multiply/divide unit
package mips_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;
  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;
  function automatic logic md_is_signed(md_op_t o);
    return o == MD_MULT || o == MD_DIV;
  endfunction
  function automatic logic md_is_mul(md_op_t o);
    return o == MD_MULT || o == MD_MULTU;
  endfunction
  function automatic logic md_is_arith(md_op_t o);
    return o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU;
  endfunction
endpackage

// File: rtl/md_sign_fix.sv
// md_sign_fix: operand magnitudes on entry, result sign correction on exit
//   a, b, is_signed     -> a_mag, b_mag (absolute values for signed ops)
//   acc, is_mul, neg_q, neg_r -> hi, lo (mult: 64-bit negate; div: separate quotient/remainder negate)
module md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic [W-1:0]   a_mag,
  output logic [W-1:0]   b_mag,
  input  logic [2*W-1:0] acc,
  input  logic           is_mul,
  input  logic           neg_q,
  input  logic           neg_r,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);
  logic [2*W-1:0] prod;
  always_comb begin
    a_mag = is_signed && a[W-1] ? -a : a;
    b_mag = is_signed && b[W-1] ? -b : b;
    prod  = neg_q ? -acc : acc;
    hi    = is_mul ? prod[2*W-1:W] : (neg_r ? -acc[2*W-1:W] : acc[2*W-1:W]);
    lo    = is_mul ? prod[W-1:0] : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide with architectural HI/LO registers
//   clk, reset (sync, active-low), start/op/a/b issue an op when not busy,
//   busy = mult/div in flight, done = one-cycle pulse when HI/LO updated by mult/div,
//   hi/lo = architectural registers.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int N  = W / BITS_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  md_state_t state, state_n;
  md_op_t op_e;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, acc_step;
  logic [W-1:0] opnd, a_mag, b_mag, hi_fix, lo_fix;
  logic [W:0] sum, diff;
  logic is_mul, neg_q, neg_r, issue_md, issue_mt, op_mul, op_sgn, last;
  assign op_e = md_op_t'(op);
  assign busy = state != IDLE;
  md_sign_fix #(.W(W)) u_sign_fix (
    .a(a), .b(b), .is_signed(op_sgn), .a_mag(a_mag), .b_mag(b_mag),
    .acc(acc), .is_mul(is_mul), .neg_q(neg_q), .neg_r(neg_r), .hi(hi_fix), .lo(lo_fix)
  );
  always_comb begin
    op_mul   = md_is_mul(op_e);
    op_sgn   = md_is_signed(op_e);
    issue_md = state == IDLE && start && md_is_arith(op_e);
    issue_mt = state == IDLE && start && (op_e == MD_MTHI || op_e == MD_MTLO);
    last     = cnt == CW'(N - 1);
    state_n  = state == IDLE ? (issue_md ? RUN : IDLE) :
               state == RUN  ? (last ? FIX : RUN) : IDLE;
  end
  // mult: shift-add into the upper half, multiplier consumed from the low end.
  // div: restoring division, remainder in the upper half, quotient shifted in at the bottom.
  always_comb begin
    acc_step = acc;
    sum      = '0;
    diff     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sum      = {1'b0, acc_step[2*W-1:W]} + (acc_step[0] ? {1'b0, opnd} : '0);
      diff     = acc_step[2*W-1:W-1] - {1'b0, opnd};
      acc_step = is_mul ? {sum, acc_step[W-1:1]} :
                 diff[W] ? {acc_step[2*W-2:0], 1'b0} : {diff[W-1:0], acc_step[W-2:0], 1'b1};
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // A zero divisor leaves quotient all ones and remainder == |a|; suppressing the
  // quotient negate and restoring the dividend sign on the remainder gives lo=~0, hi=a.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= state == FIX;
      if (issue_md) begin
        cnt    <= '0;
        is_mul <= op_mul;
        acc    <= {{W{1'b0}}, op_mul ? b_mag : a_mag};
        opnd   <= op_mul ? a_mag : b_mag;
        neg_q  <= op_sgn && (a[W-1] ^ b[W-1]) && (op_mul || |b);
        neg_r  <= op_sgn && !op_mul && a[W-1];
      end else if (state == RUN) begin
        acc <= acc_step;
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end else if (issue_mt) begin
        if (op_e == MD_MTHI) hi <= a;
        else lo <= a;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench against an arithmetic reference model
module tb_mult_div_unit;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3,
                         OP_MTHI = 3'd4, OP_MTLO = 3'd5;
  logic clk = 0, reset = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] a = 0, b = 0, hi, lo;
  logic busy, done;
  int total = 0, bad = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0;
  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l);
    longint p;
    logic [63:0] u;
    h = 0;
    l = 0;
    case (o)
      OP_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {h, l} = p;
      end
      OP_MULTU: begin
        u = {32'b0, x} * {32'b0, y};
        {h, l} = u;
      end
      OP_DIV:
        if (y == 0) begin l = '1; h = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin l = x; h = 0; end
        else begin l = $signed(x) / $signed(y); h = $signed(x) % $signed(y); end
      OP_DIVU:
        if (y == 0) begin l = '1; h = x; end
        else begin l = x / y; h = x % y; end
      default: ;
    endcase
  endfunction
  task automatic run_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] eh, el;
    int nb, g;
    model(o, x, y, eh, el);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    start = 0;
    nb = 0;
    g = 0;
    while (!done && g < 100) begin
      if (busy) nb++;
      @(negedge clk);
      g++;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_cycles"}, 32'(nb), 32'd33);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    exp_hi = eh;
    exp_lo = el;
    @(negedge clk);
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
  endtask
  task automatic run_mt(input logic [2:0] o, input logic [31:0] x, input string tag);
    @(negedge clk);
    start = 1; op = o; a = x; b = $urandom;
    @(negedge clk);
    start = 0;
    if (o == OP_MTHI) exp_hi = x;
    else exp_lo = x;
    chk({tag, ".hi"}, hi, exp_hi);
    chk({tag, ".lo"}, lo, exp_lo);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int nd, g;
    logic [31:0] eh, el, x, y;
    logic [2:0] o;
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    @(negedge clk);
    start = 1; op = OP_DIV; a = 1000; b = 7;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    chk("abort.busy_before", 32'(busy), 1);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("abort.busy", 32'(busy), 0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort.no_done", 32'(nd), 0);
    chk("abort.hi", hi, 0);
    chk("abort.lo", lo, 0);
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_md(OP_MULT, 32'hFFFF_FFF9, 32'd3, "mult_neg");
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_md(OP_DIVU, 32'd100, 32'd0, "divu_zero");
    run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(OP_DIV, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
    run_mt(OP_MTHI, 32'h1234_5678, "mthi");
    run_mt(OP_MTLO, 32'h0BAD_F00D, "mtlo");
    model(OP_MULTU, 32'h10, 32'h20, eh, el);
    @(negedge clk);
    start = 1; op = OP_MULTU; a = 32'h10; b = 32'h20;
    @(negedge clk);
    op = OP_MTLO; a = 32'hDEAD_BEEF;
    @(negedge clk);
    op = OP_MULT; a = 32'h7; b = 32'h9;
    @(negedge clk);
    start = 0;
    chk("ignore.lo_kept", lo, 32'h0BAD_F00D);
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) begin
        nd++;
        chk("ignore.hi", hi, eh);
        chk("ignore.lo", lo, el);
      end
    end
    chk("ignore.done_count", 32'(nd), 1);
    @(negedge clk);
    start = 1; op = OP_MULTU; a = 3; b = 5;
    nd = 0;
    g = 0;
    while (g < 120) begin
      @(negedge clk);
      g++;
      if (done) begin
        nd++;
        chk("b2b.hi", hi, 0);
        chk("b2b.lo", lo, 15);
      end else if (nd == 1 && start) begin
        chk("b2b.accepted", 32'(busy), 1);
        start = 0;
      end
    end
    start = 0;
    chk("b2b.done_count", 32'(nd), 2);
    exp_hi = 0;
    exp_lo = 15;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        o = 3'($urandom_range(0, 3));
        x = pick();
        y = pick();
        run_md(o, x, y, $sformatf("rnd%0d", i));
      end else begin
        o = $urandom_range(0, 1) ? OP_MTHI : OP_MTLO;
        run_mt(o, $urandom, $sformatf("rnd%0d", i));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
